// File: rtl/mul_pipe_unit_pkg.sv
// Shared operation codes, widths and op-decode helpers for the pipelined multiplier.
package mul_pipe_unit_pkg;

    localparam int unsigned REG_W    = 32;
    localparam int unsigned MUL_OP_W = 2;

    typedef enum logic [MUL_OP_W-1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHU  = 2'b10,
        MUL_OP_MULHSU = 2'b11
    } mul_op_e;

    function automatic logic op_a_signed(input mul_op_e op);
        return op != MUL_OP_MULHU;
    endfunction

    function automatic logic op_b_signed(input mul_op_e op);
        return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
    endfunction

    function automatic logic op_high(input mul_op_e op);
        return op != MUL_OP_MUL;
    endfunction

endpackage

// File: rtl/mul_pipe_unit_if.sv
// Request/response handshake bundle between the EX stage and the multiplier.
interface mul_pipe_unit_if
    import mul_pipe_unit_pkg::*;
#(
    parameter int unsigned WIDTH = REG_W,
    parameter int unsigned TAG_W = 5
) ();

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    mul_op_e          in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, busy
    );

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, busy
    );

endinterface

// File: rtl/mul_pipe_unit_slot.sv
// One pipeline slot: valid bit plus payload, loaded on enable, valid killed by flush.
module mul_pipe_unit_slot #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          load,
    input  logic          d_valid,
    input  logic [DW-1:0] d,
    output logic          q_valid,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q       <= '0;
        end else begin
            if (flush) begin
                q_valid <= 1'b0;
            end else if (load) begin
                q_valid <= d_valid;
            end
            if (load) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/mul_pipe_unit.sv
// Pipelined integer multiplier: S1 holds extended operands, middle slots carry the
// 2*WIDTH product, the last slot holds the selected result word and tag.
module mul_pipe_unit
    import mul_pipe_unit_pkg::*;
#(
    parameter int unsigned WIDTH  = REG_W,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 5
) (
    input logic            clk,
    input logic            rst,
    mul_pipe_unit_if.slave bus
);

    localparam int unsigned XW  = WIDTH + 1;
    localparam int unsigned FW  = 2 * XW;
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned S1W = MUL_OP_W + TAG_W + FW;
    localparam int unsigned CW  = MUL_OP_W + TAG_W + PW;
    localparam int unsigned LW  = TAG_W + WIDTH;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] ld;

    // A slot may load if the consumer takes a result or any slot from it onward is empty.
    for (genvar i = 0; i < STAGES; i++) begin : g_ld
        assign ld[i] = bus.out_ready | ~(&v[STAGES-1:i]);
    end

    assign bus.in_ready = ld[0] & ~bus.flush;
    assign bus.busy     = |v;

    logic [S1W-1:0]         s1_d;
    logic [S1W-1:0]         s1_q;
    mul_op_e                s1_op;
    logic [TAG_W-1:0]       s1_tag;
    logic [XW-1:0]          s1_a;
    logic [XW-1:0]          s1_b;
    logic signed [FW-1:0]   a_w;
    logic signed [FW-1:0]   b_w;
    logic [PW-1:0]          prod;

    assign s1_d = {bus.in_op, bus.in_tag,
                   op_a_signed(bus.in_op) & bus.in_a[WIDTH-1], bus.in_a,
                   op_b_signed(bus.in_op) & bus.in_b[WIDTH-1], bus.in_b};

    mul_pipe_unit_slot #(.DW(S1W)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .load    (ld[0]),
        .d_valid (bus.in_valid),
        .d       (s1_d),
        .q_valid (v[0]),
        .q       (s1_q)
    );

    assign s1_op  = mul_op_e'(s1_q[S1W-1 -: MUL_OP_W]);
    assign s1_tag = s1_q[FW+TAG_W-1 -: TAG_W];
    assign s1_a   = s1_q[FW-1 -: XW];
    assign s1_b   = s1_q[XW-1:0];

    // Extended operands are sign-extended to the full product width before multiplying.
    assign a_w  = FW'($signed(s1_a));
    assign b_w  = FW'($signed(s1_b));
    assign prod = PW'(a_w * b_w);

    logic [CW-1:0] c [STAGES-1];

    assign c[0] = {s1_op, s1_tag, prod};

    for (genvar j = 1; j < STAGES - 1; j++) begin : g_mid
        mul_pipe_unit_slot #(.DW(CW)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .flush   (bus.flush),
            .load    (ld[j]),
            .d_valid (v[j-1]),
            .d       (c[j-1]),
            .q_valid (v[j]),
            .q       (c[j])
        );
    end

    logic [CW-1:0]    cl;
    mul_op_e          cl_op;
    logic [TAG_W-1:0] cl_tag;
    logic [PW-1:0]    cl_prod;
    logic [WIDTH-1:0] cl_word;
    logic [LW-1:0]    sn_q;

    assign cl      = c[STAGES-2];
    assign cl_op   = mul_op_e'(cl[CW-1 -: MUL_OP_W]);
    assign cl_tag  = cl[PW+TAG_W-1 -: TAG_W];
    assign cl_prod = cl[PW-1:0];
    assign cl_word = op_high(cl_op) ? cl_prod[PW-1:WIDTH] : cl_prod[WIDTH-1:0];

    mul_pipe_unit_slot #(.DW(LW)) u_sn (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .load    (ld[STAGES-1]),
        .d_valid (v[STAGES-2]),
        .d       ({cl_tag, cl_word}),
        .q_valid (v[STAGES-1]),
        .q       (sn_q)
    );

    assign bus.out_valid = v[STAGES-1];
    assign bus.out_tag   = sn_q[LW-1 -: TAG_W];
    assign bus.out_data  = sn_q[WIDTH-1:0];

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Directed and randomised checks of mul_pipe_unit at STAGES=3 (32-bit) and STAGES=2/6 (16-bit).
module tb_mul_pipe_unit;
    import mul_pipe_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          due;
    } exp_t;

    mul_pipe_unit_if #(.WIDTH(32), .TAG_W(5)) b3 ();
    mul_pipe_unit_if #(.WIDTH(16), .TAG_W(5)) b2 ();
    mul_pipe_unit_if #(.WIDTH(16), .TAG_W(5)) b6 ();

    mul_pipe_unit #(.WIDTH(32), .STAGES(3), .TAG_W(5)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));
    mul_pipe_unit #(.WIDTH(16), .STAGES(2), .TAG_W(5)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
    mul_pipe_unit #(.WIDTH(16), .STAGES(6), .TAG_W(5)) u6 (.clk(clk), .rst(rst), .bus(b6.slave));

    task automatic drive3(input logic vld, input mul_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag);
        b3.in_valid = vld;
        b3.in_op    = op;
        b3.in_a     = a;
        b3.in_b     = b;
        b3.in_tag   = tag;
    endtask

    function automatic logic [15:0] ref16(input mul_op_e op, input logic [15:0] a, input logic [15:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = (op == MUL_OP_MULHU) ? longint'({48'b0, a}) : longint'($signed(a));
        sb = (op == MUL_OP_MUL || op == MUL_OP_MULH) ? longint'($signed(b)) : longint'({48'b0, b});
        p  = 64'(sa * sb);
        return (op == MUL_OP_MUL) ? p[15:0] : p[31:16];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", b3.out_valid); end
        checks++; if (b3.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", b3.busy); end
        checks++; if (b3.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h expected 0", b3.out_data); end
        checks++; if (b3.out_tag !== 5'h0) begin errors++; $display("FAIL rst_out_tag: got %h expected 0", b3.out_tag); end
        rst = 1'b0;
        #1;
        checks++; if (b3.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", b3.in_ready); end
        // Load three operations with the output stalled, then reset mid-stream.
        b3.out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            drive3(1'b1, MUL_OP_MUL, 32'(t + 2), 32'd5, 5'(t + 7));
        end
        @(negedge clk);
        drive3(1'b0, MUL_OP_MUL, 32'd0, 32'd0, 5'd0);
        checks++; if (b3.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", b3.busy); end
        rst = 1'b1;
        #1;
        checks++; if (b3.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", b3.busy); end
        checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", b3.out_valid); end
        @(negedge clk);
        rst = 1'b0;
        b3.out_ready = 1'b1;
        #1;
        checks++; if (b3.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", b3.in_ready); end
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale_%0d: got out_valid %b expected 0", t, b3.out_valid); end
        end
    endtask

    task automatic test_modes();
        mul_op_e     ops [4] = '{MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHU, MUL_OP_MULHSU};
        logic [31:0] va  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] vb  [4] = '{32'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex  [4] = '{32'h0000_002A, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        b3.out_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (t >= 3 && t < 7) begin
                checks++; if (b3.out_valid !== 1'b1) begin errors++; $display("FAIL modes_valid_%0d: got %b expected 1", t - 3, b3.out_valid); end
                checks++; if (b3.out_data !== ex[t-3]) begin errors++; $display("FAIL modes_data_%0d: got %h expected %h", t - 3, b3.out_data, ex[t-3]); end
                checks++; if (b3.out_tag !== 5'(t - 2)) begin errors++; $display("FAIL modes_tag_%0d: got %0d expected %0d", t - 3, b3.out_tag, t - 2); end
            end else begin
                checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL modes_idle_%0d: got %b expected 0", t, b3.out_valid); end
            end
            if (t < 4) begin
                drive3(1'b1, ops[t], va[t], vb[t], 5'(t + 1));
                #1;
                checks++; if (b3.in_ready !== 1'b1) begin errors++; $display("FAIL modes_in_ready_%0d: got %b expected 1", t, b3.in_ready); end
            end else begin
                drive3(1'b0, MUL_OP_MUL, 32'd0, 32'd0, 5'd0);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t q[$];
        exp_t e;
        int   acc = 0;
        b3.out_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (t >= 3) begin
                checks++; if (b3.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid_%0d: got %b expected 1", t, b3.out_valid); end
                checks++; if (b3.out_data !== 32'd3 || b3.out_tag !== 5'd10) begin errors++; $display("FAIL bp_hold_data_%0d: got %h/%0d expected 3/10", t, b3.out_data, b3.out_tag); end
            end
            drive3(1'b1, MUL_OP_MUL, 32'(t + 1), 32'd3, 5'(t + 10));
            #1;
            if (b3.in_ready) begin
                acc++;
                q.push_back('{32'(3 * (t + 1)), 5'(t + 10), 0});
            end
        end
        checks++; if (acc !== 3) begin errors++; $display("FAIL bp_accept_count: got %0d expected 3", acc); end
        @(negedge clk);
        drive3(1'b0, MUL_OP_MUL, 32'd0, 32'd0, 5'd0);
        #1;
        checks++; if (b3.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b expected 0", b3.in_ready); end
        checks++; if (b3.out_data !== 32'd3) begin errors++; $display("FAIL bp_hold_final: got %h expected 3", b3.out_data); end
        b3.out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (b3.out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got %h/%0d expected none", b3.out_data, b3.out_tag);
                end else begin
                    e = q.pop_front();
                    if (b3.out_data !== e.data || b3.out_tag !== e.tag) begin errors++; $display("FAIL bp_drain: got %h/%0d expected %h/%0d", b3.out_data, b3.out_tag, e.data, e.tag); end
                end
            end
            @(negedge clk);
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL bp_lost: got %0d left expected 0", q.size()); end
    endtask

    task automatic test_bubble();
        exp_t q[$];
        exp_t e;
        b3.out_ready = 1'b0;
        @(negedge clk);
        drive3(1'b1, MUL_OP_MULHU, 32'h0001_0000, 32'h0001_0000, 5'd20);
        #1; checks++; if (b3.in_ready !== 1'b1) begin errors++; $display("FAIL bub_ready_0: got %b expected 1", b3.in_ready); end
        q.push_back('{32'h1, 5'd20, 0});
        @(negedge clk);
        drive3(1'b0, MUL_OP_MUL, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        drive3(1'b1, MUL_OP_MULH, 32'hFFFF_FFFE, 32'd3, 5'd21);
        #1; checks++; if (b3.in_ready !== 1'b1) begin errors++; $display("FAIL bub_ready_2: got %b expected 1", b3.in_ready); end
        q.push_back('{32'hFFFF_FFFF, 5'd21, 0});
        @(negedge clk);
        drive3(1'b1, MUL_OP_MUL, 32'hFFFF_FFFF, 32'd2, 5'd22);
        #1; checks++; if (b3.in_ready !== 1'b1) begin errors++; $display("FAIL bub_ready_3: got %b expected 1", b3.in_ready); end
        q.push_back('{32'hFFFF_FFFE, 5'd22, 0});
        @(negedge clk);
        drive3(1'b0, MUL_OP_MUL, 32'd0, 32'd0, 5'd0);
        #1; checks++; if (b3.in_ready !== 1'b0) begin errors++; $display("FAIL bub_ready_full: got %b expected 0", b3.in_ready); end
        b3.out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (b3.out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bub_extra: got %h/%0d expected none", b3.out_data, b3.out_tag);
                end else begin
                    e = q.pop_front();
                    if (b3.out_data !== e.data || b3.out_tag !== e.tag) begin errors++; $display("FAIL bub_drain: got %h/%0d expected %h/%0d", b3.out_data, b3.out_tag, e.data, e.tag); end
                end
            end
            @(negedge clk);
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL bub_lost: got %0d left expected 0", q.size()); end
    endtask

    task automatic test_flush();
        b3.out_ready = 1'b1;
        @(negedge clk);
        drive3(1'b1, MUL_OP_MUL, 32'd5, 32'd5, 5'd1);
        @(negedge clk);
        drive3(1'b1, MUL_OP_MUL, 32'd6, 32'd6, 5'd2);
        @(negedge clk);
        drive3(1'b1, MUL_OP_MUL, 32'd7, 32'd7, 5'd3);
        b3.flush = 1'b1;
        #1;
        checks++; if (b3.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", b3.in_ready); end
        checks++; if (b3.busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b expected 1", b3.busy); end
        @(negedge clk);
        b3.flush = 1'b0;
        drive3(1'b0, MUL_OP_MUL, 32'd0, 32'd0, 5'd0);
        #1;
        checks++; if (b3.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", b3.busy); end
        checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", b3.out_valid); end
        checks++; if (b3.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after: got %b expected 1", b3.in_ready); end
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak_%0d: got out_valid %b expected 0", t, b3.out_valid); end
        end
    endtask

    task automatic test_sweep();
        exp_t        q2[$];
        exp_t        q6[$];
        exp_t        e;
        logic [15:0] pick [5] = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF, 16'h7FFF};
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic [4:0]  tg;
        mul_op_e     op;
        logic        ev;
        int          sent = 0;
        int          cyc  = 0;
        b2.out_ready = 1'b1;
        b6.out_ready = 1'b1;
        while (cyc < 3000 && (sent < 1000 || q2.size() > 0 || q6.size() > 0)) begin
            @(negedge clk);
            ev = (q2.size() > 0) && (q2[0].due == cyc);
            checks++;
            if (b2.out_valid !== ev) begin
                errors++; $display("FAIL s2_valid cyc %0d: got %b expected %b", cyc, b2.out_valid, ev);
            end else if (ev) begin
                e = q2.pop_front();
                checks++;
                if (b2.out_data !== e.data[15:0] || b2.out_tag !== e.tag) begin errors++; $display("FAIL s2_result cyc %0d: got %h/%0d expected %h/%0d", cyc, b2.out_data, b2.out_tag, e.data[15:0], e.tag); end
            end
            ev = (q6.size() > 0) && (q6[0].due == cyc);
            checks++;
            if (b6.out_valid !== ev) begin
                errors++; $display("FAIL s6_valid cyc %0d: got %b expected %b", cyc, b6.out_valid, ev);
            end else if (ev) begin
                e = q6.pop_front();
                checks++;
                if (b6.out_data !== e.data[15:0] || b6.out_tag !== e.tag) begin errors++; $display("FAIL s6_result cyc %0d: got %h/%0d expected %h/%0d", cyc, b6.out_data, b6.out_tag, e.data[15:0], e.tag); end
            end
            if (sent < 1000 && $urandom_range(0, 7) != 0) begin
                op = mul_op_e'($urandom_range(0, 3));
                a  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : 16'($urandom);
                b  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : 16'($urandom);
                tg = 5'($urandom);
                r  = ref16(op, a, b);
                b2.in_valid = 1'b1; b2.in_op = op; b2.in_a = a; b2.in_b = b; b2.in_tag = tg;
                b6.in_valid = 1'b1; b6.in_op = op; b6.in_a = a; b6.in_b = b; b6.in_tag = tg;
                q2.push_back('{32'(r), tg, cyc + 2});
                q6.push_back('{32'(r), tg, cyc + 6});
                sent++;
                #1;
                checks++;
                if (b2.in_ready !== 1'b1 || b6.in_ready !== 1'b1) begin errors++; $display("FAIL sweep_in_ready cyc %0d: got %b/%b expected 1/1", cyc, b2.in_ready, b6.in_ready); end
            end else begin
                b2.in_valid = 1'b0;
                b6.in_valid = 1'b0;
            end
            cyc++;
        end
        b2.in_valid = 1'b0;
        b6.in_valid = 1'b0;
        checks++;
        if (sent != 1000 || q2.size() != 0 || q6.size() != 0) begin
            errors++; $display("FAIL sweep_timeout: got sent %0d pending %0d/%0d expected 1000 0/0", sent, q2.size(), q6.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        drive3(1'b0, MUL_OP_MUL, 32'd0, 32'd0, 5'd0);
        b3.flush = 1'b0; b3.out_ready = 1'b1;
        b2.flush = 1'b0; b2.out_ready = 1'b1; b2.in_valid = 1'b0; b2.in_op = MUL_OP_MUL;
        b2.in_a = '0; b2.in_b = '0; b2.in_tag = '0;
        b6.flush = 1'b0; b6.out_ready = 1'b1; b6.in_valid = 1'b0; b6.in_op = MUL_OP_MUL;
        b6.in_a = '0; b6.in_b = '0; b6.in_tag = '0;
        test_reset();
        test_modes();
        test_backpressure();
        test_bubble();
        test_flush();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_pipe_unit.md
Name: mul_pipe_unit

Overview:
- Parametrised, multi-stage pipelined integer multiplier with a configurable number of stages.
- Supports four result modes (low word; high word signed×signed, unsigned×unsigned, signed×unsigned).
- Valid/ready handshake on both sides, per-stage stall, pipeline flush, and a destination tag carried alongside each operation.
- Sits in the EX stage beside the ALU and replaces the fixed 2-stage low-word-only multiplier.

Parameters:
- WIDTH, `RegW (32), operand and result width.
- STAGES, 3, pipeline depth; legal range 2..6; latency in cycles from accept to out_valid with no backpressure.
- TAG_W, 5, width of the opaque tag (destination register index) carried with each operation.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- flush  in  1  kill every in-flight operation.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  2  mode: 00 MUL (low), 01 MULH (s×s high), 10 MULHU (u×u high), 11 MULHSU (A signed × B unsigned, high).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_W  tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  selected result word.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (asynchronous):
  - All stage valid bits clear to 0.
  - out_valid=0, out_data=0, out_tag=0, busy=0.
  - Data registers clear to 0.
  - in_ready=1 once RST deasserts, unless flush is high.
- Pipeline structure: STAGES register slots S1..SN, each holding a valid bit, op, tag and data.
  - S1 captures the operands sign/zero-extended to WIDTH+1 bits per op: A signed for ops 00/01/11, B signed for ops 00/01.
  - The full 2*WIDTH+2-bit signed product is formed between S1 and S2.
  - S2..SN-1 delay the product; synthesis may retime the multiplier across them.
  - SN holds the final WIDTH-bit selected word: op 00 takes product[WIDTH-1:0]; all other ops take product[2*WIDTH-1:WIDTH].
  - out_valid, out_data and out_tag come directly from SN; there is no combinational path from inputs to outputs.
- Advance rule:
  - SN may load when !vN || out_ready.
  - Si may load when !vi || (Si+1 may load).
  - in_ready = (S1 may load) && !flush.
  - A transfer occurs on in_valid && in_ready, and on out_valid && out_ready.
  - A stalled stage holds its data and valid bit unchanged.
  - Bubbles collapse: an empty stage accepts from upstream even while downstream is stalled.
- Timing and throughput:
  - Throughput is 1 operation per cycle when out_ready is held at 1.
  - Latency is exactly STAGES cycles: accept at edge k gives out_valid high after edge k+STAGES-1, so out_valid is seen in the cycle following that edge.
- Ordering: results leave in acceptance order; tags are never reordered.
- Flush:
  - On the next edge every valid bit clears, including SN; an SN result presented together with out_ready in the flush cycle still counts as consumed.
  - No new operation is accepted in the flush cycle.
  - Data registers are not required to clear.
- Simultaneous events:
  - A result is consumed from SN while a new input enters S1 in the same cycle.
  - flush overrides in_valid.
  - RST overrides everything.
- Arithmetic edge cases:
  - MULH 0x80000000×0x80000000 = 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF = 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF = 0xFFFFFFFF.
  - MUL low word ignores signedness.
- Stability: out_data and out_tag stay stable while out_valid && !out_ready.

Decomposition:
- In common.vh:
  - `MUL_OP_MUL / `MUL_OP_MULH / `MUL_OP_MULHU / `MUL_OP_MULHSU (2-bit codes).
  - `MUL_OP_W = 2.
  - `RegW is reused as the WIDTH default.
- Sub-module mul_pipe_slot: one valid/data register with load enable, flush and async reset, parametrised in data width.
  - The top instantiates it STAGES times in a generate loop and computes the ready chain combinationally.

Test Plan:
- Reset behaviour: RST high mid-stream with 3 operations in flight, then release -> out_valid=0, busy=0, in_ready=1; no stale results appear.
- Latency and mode coverage: STAGES=3, out_ready=1; issue MUL 7×6 (tag 1), MULH 0x80000000×0x80000000 (tag 2), MULHU 0xFFFFFFFF×0xFFFFFFFF (tag 3), MULHSU 0xFFFFFFFF×0xFFFFFFFF (tag 4) back-to-back.
  - Required outputs in order: 0x0000002A/1, 0x40000000/2, 0xFFFFFFFE/3, 0xFFFFFFFF/4.
  - Each result appears 3 cycles after its accept, one per cycle.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 continuously.
  - Exactly STAGES operations are accepted, then in_ready=0.
  - out_data stays stable throughout.
  - On release, all results drain in order with no loss or duplication.
- Bubble collapse: issue one operation, wait 1 idle cycle, issue another, with out_ready=0.
  - Both are accepted; the second fills the gap and in_ready stays 1 until all slots are full.
- Flush: 2 operations in flight, assert flush with in_valid=1 -> next cycle busy=0 and out_valid=0; the flush-cycle input is not accepted.
- Parameter sweep: STAGES=2 and STAGES=6, WIDTH=16, 1000 random ops of all modes -> every result matches a reference model and latency equals STAGES.
